// File: rtl/sccb_write_master.sv
// rtl/sccb_write_master.sv - SCCB 3-phase write master: serialises {ID, addr, data} onto SIOC/SIOD
//
// Purpose: accepts one register write from the camera config sequencer and
// drives a complete SCCB write frame:
//   START, 3 x (8 data bits MSB first + 1 don't-care bit), STOP, bus-free.
// Every state lasts a whole number of 4-quarter bit periods. Each quarter is
// Q clk_en-cycles long, where Q = CLK_FREQ/(4*SCCB_FREQ), clamped to at least 1.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   clk_en    in   global enable; all state, including the quarter counter, advances only when high
//   start     in   write request, sampled when ready=1 and clk_en=1
//   addr      in   [7:0] register address (phase 2)
//   data      in   [7:0] register data (phase 3)
//   ready     out  1 = idle, accepts start
//   sioc      out  SCCB clock (push-pull)
//   siod_out  out  SIOD drive value
//   siod_oe   out  1 = drive SIOD with siod_out, 0 = released
//   siod_in   in   SIOD pad input           (SCCB_ACK_CHECK_EN only)
//   nack      out  sticky slave-NACK flag    (SCCB_ACK_CHECK_EN only)
//
// Optional feature macro: SCCB_ACK_CHECK_EN
`timescale 1ns/1ps

module sccb_write_master #(
    parameter int          CLK_FREQ  = 25000000,
    parameter int          SCCB_FREQ = 100000,
    parameter logic [7:0]  CAM_ID    = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       sioc,
    output logic       siod_out,
`ifdef SCCB_ACK_CHECK_EN
    input  logic       siod_in,
    output logic       nack,
`endif
    output logic       siod_oe
);

    localparam int Q_RAW = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam int CW    = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(Q - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP,
        S_BUF
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;       // clk_en-cycles within the current quarter
    logic [1:0]     qi_q, qi_d;         // quarter index 0..3
    logic [4:0]     slot_q, slot_d;     // bit slot 0..26
    logic [3:0]     bp_q, bp_d;         // position within a 9-slot phase; 8 = don't-care
    logic [23:0]    shift_q, shift_d;
    logic           ready_q, ready_d;
    logic           sioc_q, sioc_d;
    logic           siod_out_q, siod_out_d;
    logic           siod_oe_q, siod_oe_d;
`ifdef SCCB_ACK_CHECK_EN
    logic           nack_q, nack_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qi_d       = qi_q;
        slot_d     = slot_q;
        bp_d       = bp_q;
        shift_d    = shift_q;
        ready_d    = ready_q;
        sioc_d     = sioc_q;
        siod_out_d = siod_out_q;
        siod_oe_d  = siod_oe_q;
`ifdef SCCB_ACK_CHECK_EN
        nack_d     = nack_q;
`endif

        if (clk_en) begin
            if (state_q == S_IDLE) begin
                if (start) begin
                    shift_d = {CAM_ID, addr, data};
                    state_d = S_START;
                    cnt_d   = '0;
                    qi_d    = 2'd0;
                    slot_d  = 5'd0;
                    bp_d    = 4'd0;
                    ready_d = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                    nack_d  = 1'b0;
`endif
                end
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                qi_d  = qi_q + 2'd1;
                // End of a whole bit period: move to the next slot or state.
                if (qi_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_BITS;
                            slot_d  = 5'd0;
                            bp_d    = 4'd0;
                        end
                        S_BITS: begin
                            if (bp_q != 4'd8)
                                shift_d = {shift_q[22:0], 1'b0};
                            bp_d = (bp_q == 4'd8) ? 4'd0 : bp_q + 4'd1;
                            if (slot_q == 5'd26)
                                state_d = S_STOP;
                            else
                                slot_d = slot_q + 5'd1;
                        end
                        S_STOP:  state_d = S_BUF;
                        S_BUF: begin
                            state_d = S_IDLE;
                            ready_d = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

`ifdef SCCB_ACK_CHECK_EN
            // Slave ACK is sampled once, on the first cycle of q2 in a don't-care slot.
            if (state_q == S_BITS && bp_q == 4'd8 && qi_q == 2'd2 &&
                cnt_q == '0 && siod_in)
                nack_d = 1'b1;
`endif

            // Outputs follow the next state, so they only move at quarter boundaries.
            case (state_d)
                S_START: begin
                    sioc_d     = (qi_d != 2'd3);
                    siod_out_d = (qi_d == 2'd0);
                    siod_oe_d  = 1'b1;
                end
                S_BITS: begin
                    sioc_d = qi_d[1];
                    if (bp_d == 4'd8) begin
                        siod_out_d = 1'b1;
                        siod_oe_d  = 1'b0;
                    end else begin
                        siod_out_d = shift_d[23];
                        siod_oe_d  = 1'b1;
                    end
                end
                S_STOP: begin
                    sioc_d     = (qi_d != 2'd0);
                    siod_out_d = qi_d[1];
                    siod_oe_d  = (qi_d != 2'd3);
                end
                default: begin
                    sioc_d     = 1'b1;
                    siod_out_d = 1'b1;
                    siod_oe_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qi_q       <= 2'd0;
            slot_q     <= 5'd0;
            bp_q       <= 4'd0;
            shift_q    <= 24'd0;
            ready_q    <= 1'b1;
            sioc_q     <= 1'b1;
            siod_out_q <= 1'b1;
            siod_oe_q  <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            nack_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qi_q       <= qi_d;
            slot_q     <= slot_d;
            bp_q       <= bp_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            sioc_q     <= sioc_d;
            siod_out_q <= siod_out_d;
            siod_oe_q  <= siod_oe_d;
`ifdef SCCB_ACK_CHECK_EN
            nack_q     <= nack_d;
`endif
        end
    end

    assign ready    = ready_q;
    assign sioc     = sioc_q;
    assign siod_out = siod_out_q;
    assign siod_oe  = siod_oe_q;
`ifdef SCCB_ACK_CHECK_EN
    assign nack     = nack_q;
`endif

endmodule

// File: tb/tb_sccb_write_master.sv
// tb/tb_sccb_write_master.sv - directed self-checking bench for sccb_write_master
`timescale 1ns/1ps

module tb_sccb_write_master;

    localparam int FRAME = 7440;
    localparam logic [26:0] OE_EXP = 27'b111111110_111111110_111111110;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clk_en = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] addr   = 8'h00;
    logic [7:0] data   = 8'h00;
    logic       ready, sioc, siod_out, siod_oe;
`ifdef SCCB_ACK_CHECK_EN
    logic       siod_in = 1'b0;
    logic       nack;
    bit         ack_inj = 1'b0;
`endif

    always #5 clk = ~clk;

    sccb_write_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .start    (start),
        .addr     (addr),
        .data     (data),
        .ready    (ready),
        .sioc     (sioc),
        .siod_out (siod_out),
`ifdef SCCB_ACK_CHECK_EN
        .siod_in  (siod_in),
        .nack     (nack),
`endif
        .siod_oe  (siod_oe)
    );

    int n_cmp = 0;
    int n_err = 0;
    int en_div = 1;
    int ph = 0;
    int nrise, nstart, nstop, nbad, raw, lowcnt;
    logic prev_sioc, prev_line, line;
    logic [26:0] cap, capoe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        nrise = 0; nstart = 0; nstop = 0; nbad = 0; raw = 0; lowcnt = 0;
        cap = '0; capoe = '0;
        prev_sioc = sioc;
        prev_line = siod_oe ? siod_out : 1'b1;
    endtask

    // One clock: advance, sample 1 ns after the edge, update the bus monitor.
    task automatic step();
        logic pre_ready, pre_en;
        pre_ready = ready;
        pre_en    = clk_en;
        @(posedge clk);
        #1;
        if (!pre_ready) begin
            raw++;
            if (pre_en) lowcnt++;
        end
        line = siod_oe ? siod_out : 1'b1;
        if (!prev_sioc && sioc) begin
            if (nrise < 27) begin
                cap[26 - nrise]   = line;
                capoe[26 - nrise] = siod_oe;
            end
            nrise++;
        end
        if (prev_sioc && sioc && (line != prev_line)) begin
            if (!line && nrise == 0)       nstart++;
            else if (line && nrise == 28)  nstop++;
            else                           nbad++;
        end
        prev_sioc = sioc;
        prev_line = line;
        if (en_div <= 1) begin
            clk_en = 1'b1;
        end else begin
            ph = (ph + 1) % en_div;
            clk_en = (ph == 0);
        end
`ifdef SCCB_ACK_CHECK_EN
        siod_in = ack_inj && (nrise >= 17) && (nrise < 19);
`endif
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input int div,
                            input int hold, input int pulse_at, input string tag);
        int guard;
        en_div = div;
        addr   = a;
        data   = d;
        mon_clear();
        start = 1'b1;
        guard = 0;
        while (ready && guard < 10) begin
            step();
            guard++;
        end
        check_eq({tag, ".accept"}, ready, 0);
`ifdef SCCB_ACK_CHECK_EN
        check_eq({tag, ".nack_clr"}, nack, 0);
`endif
        for (int i = 1; i < hold; i++) step();
        start = 1'b0;
        guard = 0;
        while (!ready && guard < 30000) begin
            step();
            guard++;
            if (guard == pulse_at) start = 1'b1;
            else                   start = 1'b0;
        end
        start = 1'b0;
        check_eq({tag, ".done"},    ready, 1);
        check_eq({tag, ".id"},      cap[26:19], 8'h42);
        check_eq({tag, ".addr"},    cap[17:10], a);
        check_eq({tag, ".data"},    cap[8:1], d);
        check_eq({tag, ".oe_mask"}, capoe, OE_EXP);
        check_eq({tag, ".len"},     lowcnt, FRAME);
        check_eq({tag, ".raw"},     raw, FRAME * div);
        check_eq({tag, ".rises"},   nrise, 28);
        check_eq({tag, ".start"},   nstart, 1);
        check_eq({tag, ".stop"},    nstop, 1);
        check_eq({tag, ".glitch"},  nbad, 0);
    endtask

    initial begin
        int g;
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.ready",    ready, 1);
        check_eq("rst.sioc",     sioc, 1);
        check_eq("rst.siod_out", siod_out, 1);
        check_eq("rst.siod_oe",  siod_oe, 0);
`ifdef SCCB_ACK_CHECK_EN
        check_eq("rst.nack",     nack, 0);
`endif
        rst_n = 1'b1;
        repeat (3) step();

        do_frame(8'h12, 8'h80, 1, 1, 0, "basic");

        // start held two cycles, then pulsed mid-frame: only one frame may result
        do_frame(8'hA5, 8'h3C, 1, 2, 3000, "hold");
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!ready || !sioc || siod_oe) ok = 1'b0;
        end
        check_eq("hold.no_requeue", ok, 1);

        do_frame(8'h12, 8'h80, 3, 1, 0, "slow");
        en_div = 1;
        repeat (2) step();

        // reset in the middle of bit 10
        mon_clear();
        addr  = 8'h77;
        data  = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (nrise < 10 && g < 20000) begin
            step();
            g++;
        end
        check_eq("midrst.reach", nrise, 10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst.ready_now", ready, 1);
        check_eq("midrst.sioc_now",  sioc, 1);
        check_eq("midrst.oe_now",    siod_oe, 0);
        step();
        check_eq("midrst.ready", ready, 1);
        check_eq("midrst.sioc",  sioc, 1);
        check_eq("midrst.oe",    siod_oe, 0);
        rst_n = 1'b1;
        repeat (2) step();
        do_frame(8'h5A, 8'hC3, 1, 1, 0, "postrst");

`ifdef SCCB_ACK_CHECK_EN
        ack_inj = 1'b1;
        do_frame(8'h12, 8'h80, 1, 1, 0, "ack");
        ack_inj = 1'b0;
        siod_in = 1'b0;
        check_eq("ack.nack_set", nack, 1);
        do_frame(8'h01, 8'h02, 1, 1, 0, "ack2");
        check_eq("ack2.nack_clear", nack, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
